// File: rtl/vx_tlb_dm.sv
// -----------------------------------------------------------------------------
// vx_tlb_dm -- direct-mapped TLB for an Sv32-style MMU.
//
// Maps a 20-bit virtual page number to a 22-bit physical page number plus an
// 8-bit access tag. The page-table walker fills entries through the write
// port. The core issues resolve requests, and each result appears one cycle
// later.
//
// Ports:
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous reset, active-HIGH despite the name
//   enable             in   1 = translate, 0 = bare/bypass mode
//   resolve            in   lookup request
//   virtual_address    in   [19:0] VPN to look up
//   write              in   fill request
//   virtual_address_w  in   [19:0] VPN of the entry being filled
//   phys_w             in   [21:0] PPN to store
//   accesstag_w        in   [7:0]  access tag to store
//   invalidate         in   flush all valid bits (wins over a same-edge write)
//   done               out  result valid, one cycle per sampled resolve
//   miss               out  lookup missed, qualified by done
//   phys_r             out  [21:0] PPN result, holds when no hit or bypass
//   accesstag_r        out  [7:0]  access tag result, holds likewise
//   hit_count          out  [31:0] only with VX_TLB_PERF_COUNTERS_EN
//   miss_count         out  [31:0] only with VX_TLB_PERF_COUNTERS_EN
//
// Optional feature macro: VX_TLB_PERF_COUNTERS_EN (hit/miss counters).
// -----------------------------------------------------------------------------
module vx_tlb_dm #(
    parameter int ENTRIES_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        resolve,
    input  logic [19:0] virtual_address,
    input  logic        write,
    input  logic [19:0] virtual_address_w,
    input  logic [21:0] phys_w,
    input  logic [7:0]  accesstag_w,
    input  logic        invalidate,
    output logic        done,
    output logic        miss,
    output logic [21:0] phys_r,
    output logic [7:0]  accesstag_r
`ifdef VX_TLB_PERF_COUNTERS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int ENTRIES = 1 << ENTRIES_W;
    localparam int TAG_W   = 20 - ENTRIES_W;

    // Entry storage.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [21:0]        phys_q [ENTRIES];
    logic [7:0]         atag_q [ENTRIES];

    // Request decode.
    logic [ENTRIES_W-1:0] rd_idx;
    logic [TAG_W-1:0]     rd_tag;
    logic [ENTRIES_W-1:0] wr_idx;
    logic                 hit;

    assign rd_idx = virtual_address[ENTRIES_W-1:0];
    assign rd_tag = virtual_address[19:ENTRIES_W];
    assign wr_idx = virtual_address_w[ENTRIES_W-1:0];

    // The lookup reads registered array state. A same-edge write or invalidate
    // therefore lands after this lookup has sampled the entry.
    assign hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    // Result registers.
    logic        done_q, done_d;
    logic        miss_q, miss_d;
    logic [21:0] phys_r_q, phys_r_d;
    logic [7:0]  atag_r_q, atag_r_d;

    // Valid bits. Invalidate takes priority and drops a concurrent write.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, which gives the "lookup sees old contents" ordering.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_q <= '0;
        end else if (invalidate) begin
            valid_q <= '0;
        end else if (write) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays. The valid bits alone define occupancy, so these
    // arrays hold no meaningful state after reset.
    // NOTE: arrays are deliberately left out of reset so they map onto plain
    // RAM or flops without reset muxes.
    always_ff @(posedge clk) begin
        if (write && !invalidate) begin
            tag_q[wr_idx]  <= virtual_address_w[19:ENTRIES_W];
            phys_q[wr_idx] <= phys_w;
            atag_q[wr_idx] <= accesstag_w;
        end
    end

    // Next-state of the result registers.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        done_d   = 1'b0;
        miss_d   = 1'b0;
        phys_r_d = phys_r_q;
        atag_r_d = atag_r_q;
        if (resolve) begin
            done_d = 1'b1;
            if (!enable) begin
                // Bare mode: identity mapping, full access, array not consulted.
                phys_r_d = {2'b00, virtual_address};
                atag_r_d = 8'hFF;
            end else if (hit) begin
                phys_r_d = phys_q[rd_idx];
                atag_r_d = atag_q[rd_idx];
            end else begin
                miss_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            done_q   <= 1'b0;
            miss_q   <= 1'b0;
            phys_r_q <= '0;
            atag_r_q <= '0;
        end else begin
            done_q   <= done_d;
            miss_q   <= miss_d;
            phys_r_q <= phys_r_d;
            atag_r_q <= atag_r_d;
        end
    end

    assign done        = done_q;
    assign miss        = miss_q;
    assign phys_r      = phys_r_q;
    assign accesstag_r = atag_r_q;

`ifdef VX_TLB_PERF_COUNTERS_EN
    // The counters update on the same edge that raises done, so they already
    // include the result being presented. Bypass lookups count as neither.
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (resolve && enable) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_vx_tlb_dm.sv
// -----------------------------------------------------------------------------
// tb_vx_tlb_dm -- self-checking bench for vx_tlb_dm (ENTRIES_W = 4).
// A table of per-cycle vectors carries hand-derived expected outputs. Each
// expectation is queued when its vector is driven and popped after the edge.
// A hand-written sequence covers reset in the middle of a lookup.
// -----------------------------------------------------------------------------
module tb_vx_tlb_dm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        resolve;
    logic [19:0] virtual_address;
    logic        write;
    logic [19:0] virtual_address_w;
    logic [21:0] phys_w;
    logic [7:0]  accesstag_w;
    logic        invalidate;
    logic        done;
    logic        miss;
    logic [21:0] phys_r;
    logic [7:0]  accesstag_r;
`ifdef VX_TLB_PERF_COUNTERS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    int          exp_hits;
    int          exp_misses;
`endif

    always #5 clk = ~clk;

    vx_tlb_dm #(.ENTRIES_W(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .resolve           (resolve),
        .virtual_address   (virtual_address),
        .write             (write),
        .virtual_address_w (virtual_address_w),
        .phys_w            (phys_w),
        .accesstag_w       (accesstag_w),
        .invalidate        (invalidate),
        .done              (done),
        .miss              (miss),
        .phys_r            (phys_r),
        .accesstag_r       (accesstag_r)
`ifdef VX_TLB_PERF_COUNTERS_EN
        ,
        .hit_count         (hit_count),
        .miss_count        (miss_count)
`endif
    );

    typedef struct {
        logic        en;
        logic        res;
        logic [19:0] va;
        logic        wr;
        logic [19:0] vaw;
        logic [21:0] pw;
        logic [7:0]  tw;
        logic        inv;
        logic        e_done;
        logic        e_miss;
        logic [21:0] e_phys;
        logic [7:0]  e_tag;
    } vec_t;

    typedef struct {
        logic        done;
        logic        miss;
        logic [21:0] phys;
        logic [7:0]  tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic add(input logic en, input logic res, input logic [19:0] va,
                       input logic wr, input logic [19:0] vaw, input logic [21:0] pw,
                       input logic [7:0] tw, input logic inv,
                       input logic e_done, input logic e_miss,
                       input logic [21:0] e_phys, input logic [7:0] e_tag);
        vec_t v;
        v.en = en; v.res = res; v.va = va; v.wr = wr; v.vaw = vaw; v.pw = pw;
        v.tw = tw; v.inv = inv; v.e_done = e_done; v.e_miss = e_miss;
        v.e_phys = e_phys; v.e_tag = e_tag;
        vecs.push_back(v);
    endtask

    // Drive one vector at the falling edge, then compare just after the rising edge.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        enable            = v.en;
        resolve           = v.res;
        virtual_address   = v.va;
        write             = v.wr;
        virtual_address_w = v.vaw;
        phys_w            = v.pw;
        accesstag_w       = v.tw;
        invalidate        = v.inv;
        sb.push_back('{v.e_done, v.e_miss, v.e_phys, v.e_tag});
`ifdef VX_TLB_PERF_COUNTERS_EN
        if (v.res && v.en) begin
            if (v.e_miss) exp_misses++;
            else          exp_hits++;
        end
`endif
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({name, ".done"},        {31'd0, done}, {31'd0, e.done});
            check({name, ".miss"},        {31'd0, miss}, {31'd0, e.miss});
            check({name, ".phys_r"},      {10'd0, phys_r}, {10'd0, e.phys});
            check({name, ".accesstag_r"}, {24'd0, accesstag_r}, {24'd0, e.tag});
`ifdef VX_TLB_PERF_COUNTERS_EN
            check({name, ".hit_count"},  hit_count,  exp_hits);
            check({name, ".miss_count"}, miss_count, exp_misses);
`endif
        end
    endtask

    initial begin
        vec_t v;
        enable = 1'b0; resolve = 1'b0; virtual_address = '0; write = 1'b0;
        virtual_address_w = '0; phys_w = '0; accesstag_w = '0; invalidate = 1'b0;
`ifdef VX_TLB_PERF_COUNTERS_EN
        exp_hits = 0; exp_misses = 0;
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset.done",        {31'd0, done}, 32'd0);
        check("reset.miss",        {31'd0, miss}, 32'd0);
        check("reset.phys_r",      {10'd0, phys_r}, 32'd0);
        check("reset.accesstag_r", {24'd0, accesstag_r}, 32'd0);
`ifdef VX_TLB_PERF_COUNTERS_EN
        check("reset.hit_count",  hit_count,  32'd0);
        check("reset.miss_count", miss_count, 32'd0);
`endif
        rst_n = 1'b0;

        //   en res va        wr vaw       pw         tw     inv  done miss phys       tag
        add(0, 1, 20'h00000, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h000000, 8'hFF); // bypass 1
        add(0, 1, 20'h00000, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h000000, 8'hFF); // bypass 2
        add(1, 0, 20'h00000, 0, 20'h0,    22'h0,     8'h00, 0,   0, 0, 22'h000000, 8'hFF); // done drops
        add(1, 1, 20'h20000, 0, 20'h0,    22'h0,     8'h00, 0,   1, 1, 22'h000000, 8'hFF); // cold miss
        add(1, 0, 20'h00000, 0, 20'h0,    22'h0,     8'h00, 0,   0, 0, 22'h000000, 8'hFF);
        add(1, 0, 20'h00000, 1, 20'h20000, 22'h10000, 8'hB1, 0,  0, 0, 22'h000000, 8'hFF); // fills
        add(1, 0, 20'h00000, 1, 20'h20001, 22'h10001, 8'hB3, 0,  0, 0, 22'h000000, 8'hFF);
        add(1, 0, 20'h00000, 1, 20'h20002, 22'h10002, 8'hB5, 0,  0, 0, 22'h000000, 8'hFF);
        add(1, 1, 20'h20000, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h010000, 8'hB1); // back-to-back hits
        add(1, 1, 20'h20001, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h010001, 8'hB3);
        add(1, 1, 20'h20002, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h010002, 8'hB5);
        add(1, 0, 20'h00000, 0, 20'h0,    22'h0,     8'h00, 0,   0, 0, 22'h010002, 8'hB5); // outputs hold
        add(1, 0, 20'h00000, 1, 20'h30000, 22'h3ABCD, 8'h0F, 0,  0, 0, 22'h010002, 8'hB5); // conflict fill
        add(1, 1, 20'h20000, 0, 20'h0,    22'h0,     8'h00, 0,   1, 1, 22'h010002, 8'hB5); // evicted
        add(1, 1, 20'h30000, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h03ABCD, 8'h0F);
        add(0, 1, 20'hABCDE, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h0ABCDE, 8'hFF); // bypass, nonzero VA
        add(1, 0, 20'h00000, 0, 20'h0,    22'h0,     8'h00, 1,   0, 0, 22'h0ABCDE, 8'hFF); // invalidate
        add(1, 1, 20'h20002, 0, 20'h0,    22'h0,     8'h00, 0,   1, 1, 22'h0ABCDE, 8'hFF);
        add(1, 0, 20'h00000, 1, 20'h20001, 22'h11111, 8'h22, 0,  0, 0, 22'h0ABCDE, 8'hFF);
        add(1, 1, 20'h20001, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h011111, 8'h22);
        add(1, 0, 20'h00000, 1, 20'h20001, 22'h2AAAA, 8'h33, 1,  0, 0, 22'h011111, 8'h22); // inv beats write
        add(1, 1, 20'h20001, 0, 20'h0,    22'h0,     8'h00, 0,   1, 1, 22'h011111, 8'h22);
        add(1, 1, 20'h20005, 1, 20'h20005, 22'h05555, 8'h55, 0,  1, 1, 22'h011111, 8'h22); // same-edge write
        add(1, 1, 20'h20005, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h005555, 8'h55);
        add(1, 1, 20'h20005, 0, 20'h0,    22'h0,     8'h00, 1,   1, 0, 22'h005555, 8'h55); // same-edge invalidate
        add(1, 1, 20'h20005, 0, 20'h0,    22'h0,     8'h00, 0,   1, 1, 22'h005555, 8'h55);
        add(1, 0, 20'h00000, 1, 20'h3FFFF, 22'h3FFFFF, 8'hAA, 0, 0, 0, 22'h005555, 8'h55); // top index
        add(1, 1, 20'h3FFFF, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h3FFFFF, 8'hAA);
        add(1, 1, 20'h2FFFF, 0, 20'h0,    22'h0,     8'h00, 0,   1, 1, 22'h3FFFFF, 8'hAA); // tag mismatch
        add(0, 0, 20'h00000, 1, 20'h00007, 22'h00077, 8'h77, 0,  0, 0, 22'h3FFFFF, 8'hAA); // write while bypass
        add(1, 1, 20'h00007, 0, 20'h0,    22'h0,     8'h00, 0,   1, 0, 22'h000077, 8'h77);
        add(1, 0, 20'h00000, 0, 20'h0,    22'h0,     8'h00, 0,   0, 0, 22'h000077, 8'h77);

        foreach (vecs[i]) begin
            v = vecs[i];
            apply(v, $sformatf("vec%0d", i));
        end

        // Reset during a lookup: done is up, and an async reset must clear it at once.
        v = '{1, 1, 20'h00007, 0, 20'h0, 22'h0, 8'h00, 0, 1, 0, 22'h000077, 8'h77};
        apply(v, "pre_reset_hit");
        #2;
        rst_n = 1'b1;
        #1;
        check("midreset.done",        {31'd0, done}, 32'd0);
        check("midreset.miss",        {31'd0, miss}, 32'd0);
        check("midreset.phys_r",      {10'd0, phys_r}, 32'd0);
        check("midreset.accesstag_r", {24'd0, accesstag_r}, 32'd0);
`ifdef VX_TLB_PERF_COUNTERS_EN
        check("midreset.hit_count",  hit_count,  32'd0);
        check("midreset.miss_count", miss_count, 32'd0);
        exp_hits = 0; exp_misses = 0;
`endif
        @(negedge clk);
        rst_n = 1'b0;
        // The valid bits were cleared by reset, so the earlier fill must miss now.
        v = '{1, 1, 20'h00007, 0, 20'h0, 22'h0, 8'h00, 0, 1, 1, 22'h000000, 8'h00};
        apply(v, "post_reset_miss");
        v = '{1, 0, 20'h00000, 0, 20'h0, 22'h0, 8'h00, 0, 0, 0, 22'h000000, 8'h00};
        apply(v, "post_reset_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
